// File: rtl/td4_core_ctrl.sv
// TD4 instruction sequencer / datapath controller: FETCH->EXEC FSM driving one shared 4-bit adder.
// Optional single-step gating of FETCH is enabled by defining TD4_STEP_EN.

module adder4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [3:0] s,
    output logic       co
);
    assign {co, s} = {1'b0, x} + {1'b0, y};
endmodule

module td4_core_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] rom_addr,
    input  logic [7:0] rom_data,
    input  logic [3:0] in_port,
    output logic [3:0] out_port,
    output logic       carry,
    output logic       exec
`ifdef TD4_STEP_EN
    ,
    input  logic       step
`endif
);

    typedef enum logic {S_FETCH, S_EXEC} state_t;
    typedef enum logic [1:0] {X_ZERO, X_A, X_B, X_IN} xsel_t;

    typedef struct packed {
        xsel_t x_sel;
        logic  wr_a;
        logic  wr_b;
        logic  wr_out;
        logic  jmp;
        logic  jnc;
    } ctrl_t;

    state_t     state_q, state_d;
    logic [7:0] ir;
    logic [3:0] reg_a, reg_b, reg_out, pc;
    logic       c_flag;
    logic       ir_load;
    logic       advance;
    ctrl_t      ctrl;
    logic [3:0] alu_x, alu_s;
    logic       alu_co;
    logic       jump_taken;
    logic [3:0] pc_next;

`ifdef TD4_STEP_EN
    assign advance = step;
`else
    assign advance = 1'b1;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ir_load = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (advance) begin
                    ir_load = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC:  state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
    end

    // ---------------- decode ----------------
    // Unlisted opcodes fall through as NOPs with X=0, which also clears C.
    always_comb begin
        ctrl = '{x_sel: X_ZERO, wr_a: 1'b0, wr_b: 1'b0, wr_out: 1'b0, jmp: 1'b0, jnc: 1'b0};
        case (ir[7:4])
            4'b0000: begin ctrl.x_sel = X_A;    ctrl.wr_a   = 1'b1; end
            4'b0101: begin ctrl.x_sel = X_B;    ctrl.wr_b   = 1'b1; end
            4'b0011: begin ctrl.x_sel = X_ZERO; ctrl.wr_a   = 1'b1; end
            4'b0111: begin ctrl.x_sel = X_ZERO; ctrl.wr_b   = 1'b1; end
            4'b0001: begin ctrl.x_sel = X_B;    ctrl.wr_a   = 1'b1; end
            4'b0100: begin ctrl.x_sel = X_A;    ctrl.wr_b   = 1'b1; end
            4'b0010: begin ctrl.x_sel = X_IN;   ctrl.wr_a   = 1'b1; end
            4'b0110: begin ctrl.x_sel = X_IN;   ctrl.wr_b   = 1'b1; end
            4'b1001: begin ctrl.x_sel = X_B;    ctrl.wr_out = 1'b1; end
            4'b1011: begin ctrl.x_sel = X_ZERO; ctrl.wr_out = 1'b1; end
            4'b1111: ctrl.jmp = 1'b1;
            4'b1110: ctrl.jnc = 1'b1;
            default: ;
        endcase
    end

    // ---------------- ALU ----------------
    always_comb begin
        alu_x = 4'd0;
        case (ctrl.x_sel)
            X_A:     alu_x = reg_a;
            X_B:     alu_x = reg_b;
            X_IN:    alu_x = in_port;
            default: alu_x = 4'd0;
        endcase
    end

    adder4 u_alu (
        .x  (alu_x),
        .y  (ir[3:0]),
        .s  (alu_s),
        .co (alu_co)
    );

    // JNC looks at C as it stood before this EXEC edge.
    assign jump_taken = ctrl.jmp | (ctrl.jnc & ~c_flag);
    assign pc_next    = jump_taken ? ir[3:0] : pc + 4'd1;

    // ---------------- architectural state ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir      <= 8'd0;
            reg_a   <= 4'd0;
            reg_b   <= 4'd0;
            reg_out <= 4'd0;
            pc      <= 4'd0;
            c_flag  <= 1'b0;
        end else begin
            if (ir_load) ir <= rom_data;
            if (state_q == S_EXEC) begin
                c_flag <= alu_co;
                pc     <= pc_next;
                if (ctrl.wr_a)   reg_a   <= alu_s;
                if (ctrl.wr_b)   reg_b   <= alu_s;
                if (ctrl.wr_out) reg_out <= alu_s;
            end
        end
    end

    assign rom_addr = pc;
    assign out_port = reg_out;
    assign carry    = c_flag;
    assign exec     = (state_q == S_EXEC);

endmodule

// File: tb/tb_td4_core_ctrl.sv
// Directed bench for td4_core_ctrl: a program table checked per instruction plus
// hand-written reset, branch, wrap and (with TD4_STEP_EN) single-step sequences.

module tb_td4_core_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic [3:0] in_port;
    logic [3:0] out_port;
    logic       carry;
    logic       exec;
`ifdef TD4_STEP_EN
    logic       step;
`endif

    logic [7:0] rom [16];
    assign rom_data = rom[rom_addr];

    int n_cmp  = 0;
    int n_fail = 0;

    td4_core_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .in_port  (in_port),
        .out_port (out_port),
        .carry    (carry),
        .exec     (exec)
`ifdef TD4_STEP_EN
        ,
        .step     (step)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] in_val;
        logic [3:0] exp_pc;
        logic [3:0] exp_out;
        logic       exp_c;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fill_rom(input logic [7:0] v);
        for (int i = 0; i < 16; i++) rom[i] = v;
    endtask

    // Leaves the bench at a negedge with reset just released.
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One instruction: FETCH edge, drive in_port mid-EXEC, EXEC edge, sample.
    task automatic run_instr(input logic [3:0] in_val);
        @(negedge clk);
        in_port = in_val;
        @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        in_port = 4'd0;
`ifdef TD4_STEP_EN
        step    = 1'b1;
`endif
        // main program
        rom[0]  = 8'h35; rom[1]  = 8'h03; rom[2]  = 8'h40; rom[3]  = 8'h90;
        rom[4]  = 8'h70; rom[5]  = 8'h90; rom[6]  = 8'h3F; rom[7]  = 8'h02;
        rom[8]  = 8'hE0; rom[9]  = 8'h40; rom[10] = 8'h90; rom[11] = 8'h62;
        rom[12] = 8'h91; rom[13] = 8'hBF; rom[14] = 8'h9F; rom[15] = 8'hF3;

        vecs[0]  = '{4'h0, 4'd1,  4'h0, 1'b0};  // MOV A,5
        vecs[1]  = '{4'h0, 4'd2,  4'h0, 1'b0};  // ADD A,3 -> A=8
        vecs[2]  = '{4'h0, 4'd3,  4'h0, 1'b0};  // MOV B,A
        vecs[3]  = '{4'h0, 4'd4,  4'h8, 1'b0};  // OUT B -> 8
        vecs[4]  = '{4'h0, 4'd5,  4'h8, 1'b0};  // MOV B,0
        vecs[5]  = '{4'h0, 4'd6,  4'h0, 1'b0};  // OUT B -> 0
        vecs[6]  = '{4'h0, 4'd7,  4'h0, 1'b0};  // MOV A,15
        vecs[7]  = '{4'h0, 4'd8,  4'h0, 1'b1};  // ADD A,2 -> A=1, C=1
        vecs[8]  = '{4'h0, 4'd9,  4'h0, 1'b0};  // JNC 0 not taken, C cleared
        vecs[9]  = '{4'h0, 4'd10, 4'h0, 1'b0};  // MOV B,A -> B=1
        vecs[10] = '{4'h0, 4'd11, 4'h1, 1'b0};  // OUT B -> 1
        vecs[11] = '{4'hA, 4'd12, 4'h1, 1'b0};  // IN B,2 -> B=C
        vecs[12] = '{4'h0, 4'd13, 4'hD, 1'b0};  // OUT B,1 -> D
        vecs[13] = '{4'h0, 4'd14, 4'hF, 1'b0};  // OUT 15
        vecs[14] = '{4'h0, 4'd15, 4'hB, 1'b1};  // OUT B,15 -> C+F = 1B
        vecs[15] = '{4'h0, 4'd3,  4'hB, 1'b0};  // JMP 3 (not PC wrap)
        vecs[16] = '{4'h0, 4'd4,  4'hC, 1'b0};  // OUT B -> C

        @(negedge clk);
        check("reset_rom_addr", {4'd0, rom_addr}, 8'd0);
        check("reset_out",      {4'd0, out_port}, 8'd0);
        check("reset_carry",    {7'd0, carry},    8'd0);
        check("reset_exec",     {7'd0, exec},     8'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            check($sformatf("v%0d_exec_hi", i), {7'd0, exec}, 8'd1);
            in_port = vecs[i].in_val;
            @(negedge clk);
            check($sformatf("v%0d_exec_lo", i), {7'd0, exec},     8'd0);
            check($sformatf("v%0d_pc", i),      {4'd0, rom_addr}, {4'd0, vecs[i].exp_pc});
            check($sformatf("v%0d_out", i),     {4'd0, out_port}, {4'd0, vecs[i].exp_out});
            check($sformatf("v%0d_carry", i),   {7'd0, carry},    {7'd0, vecs[i].exp_c});
        end
        in_port = 4'd0;

        // JNC taken with C=0
        fill_rom(8'h80);
        rom[0] = 8'h33; rom[1] = 8'h01; rom[2] = 8'hE9;
        do_reset();
        run_instr(4'd0);
        run_instr(4'd0);
        check("jnc_pre_carry", {7'd0, carry},    8'd0);
        run_instr(4'd0);
        check("jnc_taken_pc",  {4'd0, rom_addr}, 8'd9);
        check("jnc_carry",     {7'd0, carry},    8'd0);

        // PC wrap over 16 instructions; OUT stays at 6 across NOPs
        fill_rom(8'h80);
        rom[0] = 8'hB6;
        do_reset();
        for (int i = 0; i < 8; i++) run_instr(4'd0);
        check("wrap_mid_pc",  {4'd0, rom_addr}, 8'd8);
        for (int i = 0; i < 8; i++) run_instr(4'd0);
        check("wrap_pc",      {4'd0, rom_addr}, 8'd0);
        check("wrap_out",     {4'd0, out_port}, 8'd6);
        check("wrap_carry",   {7'd0, carry},    8'd0);

        // async reset mid-EXEC of ADD A,7
        fill_rom(8'h80);
        rom[0] = 8'h3C; rom[1] = 8'hB5; rom[2] = 8'h07;
        do_reset();
        run_instr(4'd0);
        run_instr(4'd0);
        check("pre_rst_out", {4'd0, out_port}, 8'd5);
        @(negedge clk);
        check("pre_rst_exec", {7'd0, exec}, 8'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out",   {4'd0, out_port}, 8'd0);
        check("arst_pc",    {4'd0, rom_addr}, 8'd0);
        check("arst_carry", {7'd0, carry},    8'd0);
        check("arst_exec",  {7'd0, exec},     8'd0);
        rom[0] = 8'h40; rom[1] = 8'h90;
        @(negedge clk);
        rst_n = 1'b1;
        run_instr(4'd0);
        run_instr(4'd0);
        check("post_rst_out", {4'd0, out_port}, 8'd0);
        check("post_rst_pc",  {4'd0, rom_addr}, 8'd2);

`ifdef TD4_STEP_EN
        fill_rom(8'h80);
        rom[0] = 8'hB9;
        step = 1'b0;
        do_reset();
        repeat (10) @(negedge clk);
        check("step_hold_pc",   {4'd0, rom_addr}, 8'd0);
        check("step_hold_exec", {7'd0, exec},     8'd0);
        check("step_hold_out",  {4'd0, out_port}, 8'd0);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        check("step_exec", {7'd0, exec}, 8'd1);
        @(negedge clk);
        check("step_pc",  {4'd0, rom_addr}, 8'd1);
        check("step_out", {4'd0, out_port}, 8'd9);
        repeat (6) @(negedge clk);
        check("step_idle_pc",   {4'd0, rom_addr}, 8'd1);
        check("step_idle_exec", {7'd0, exec},     8'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
